apb_slave_regbank: RTL and testbench
====================================

// Module: apb_slave_regbank
// PURPOSE
//  Parametrised APB slave register bank. NUM_REGS x DATA_W registers with byte strobes,
//  programmable wait states, read-only masking and PSLVERR on illegal accesses.
//  Sits behind the APB master/decoder and drives its registers to fabric via regs_o.
// PARAMETERS
//  DATA_W      32        data bus width; multiple of 8
//  ADDR_W      8         PADDR width; word index = PADDR[ADDR_W-1:2]
//  NUM_REGS    4         register count, 1..2**(ADDR_W-2)
//  WAIT_CYCLES 0         wait states inserted before PREADY, 0..15
//  RO_MASK     '0        NUM_REGS bits; bit i=1 -> reg i read-only
// PORTS
//  PCLK     in   1                  clock; all logic on rising edge
//  PRESET   in   1                  synchronous, active-high reset
//  PADDR    in   ADDR_W             byte address
//  PSEL     in   1                  slave select
//  PENABLE  in   1                  access phase
//  PWRITE   in   1                  1=write, 0=read
//  PWDATA   in   DATA_W             write data
//  PSTRB    in   DATA_W/8           write byte strobes
//  PRDATA   out  DATA_W             read data, valid when PREADY=1
//  PREADY   out  1                  transfer complete, registered
//  PSLVERR  out  1                  error, valid only when PREADY=1
//  regs_o   out  NUM_REGS*DATA_W    flat register contents, reg i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset: all regs, PRDATA, PREADY, PSLVERR = 0; FSM -> IDLE; wait counter = 0.
//  FSM (registered outputs):
//   IDLE : PSEL&PENABLE -> WAIT_CYCLES==0 ? DONE : WAIT (cnt <= WAIT_CYCLES-1).
//   WAIT : PSEL&PENABLE must stay high; cnt==0 -> DONE, else cnt--.
//          PSEL or PENABLE low in WAIT -> IDLE, no commit, no PREADY (abort).
//   DONE : PREADY=1 for exactly one cycle; -> IDLE unconditionally.
//  Latency: first access cycle at edge N -> PREADY high in cycle N+1+WAIT_CYCLES.
//  Commit/load happens on the edge entering DONE, using PADDR/PWRITE/PWDATA/PSTRB
//   sampled on that edge (APB holds them stable through the access phase).
//  Error (err) = PADDR[1:0]!=0 | index>=NUM_REGS | (PWRITE & RO_MASK[index]).
//  Write, no err: for each byte b with PSTRB[b]=1, reg[index][8b+:8] <= PWDATA[8b+:8];
//   PSTRB=0 -> legal write, no change.
//  Write, err: no register changes; PSLVERR=1 in DONE.
//  Read, no err: PRDATA <= reg[index]. Read, err: PRDATA <= 0, PSLVERR=1.
//  PRDATA holds last value outside DONE; PSLVERR is 0 outside DONE.
//  Back-to-back: next transfer's access phase detected in IDLE the cycle after DONE
//   (min transfer = setup + access + 1 cycle at WAIT_CYCLES=0).
//  Reset mid-transfer (WAIT or DONE): reset wins; no commit; PREADY=0 next cycle.
//  Reads of RO regs are legal; RO regs hold reset value 0 unless written by fabric
//   (not in this block: RO regs are constant 0 here).
// STRUCTURE
//  apb_pkg: typedef enum logic [1:0] {APB_IDLE, APB_WAIT, APB_DONE} apb_slv_state_e;
//   localparam APB_WAIT_CNT_W = 4.
//  Sub-module apb_regbank_core: register array + byte-strobe write + read mux + error
//   decode (combinational err/rdata, sequential regs); top holds FSM and output regs.
// TESTING (DATA_W=32, ADDR_W=8, NUM_REGS=4, RO_MASK=4'b1000 unless noted)
//  1 WAIT_CYCLES=0: write 0xDEADBEEF @0x04 PSTRB=4'hF, read @0x04 -> PREADY 1 cycle
//    after access start, PRDATA=0xDEADBEEF, PSLVERR=0, regs_o[63:32]=0xDEADBEEF.
//  2 Byte strobes: write 0x11223344 @0x00 PSTRB=4'hF, then 0xAABBCCDD PSTRB=4'b0101
//    -> read @0x00 returns 0x11BB33DD.
//  3 Errors: write @0x0C (RO), write @0x10 (out of range), read @0x02 (misaligned)
//    -> PSLVERR=1 each, regs unchanged, PRDATA=0 on read.
//  4 WAIT_CYCLES=3: read @0x08 -> PREADY low 3 access cycles, high on 4th; one cycle only.
//  5 Abort/reset: WAIT_CYCLES=3, drop PSEL in WAIT -> no PREADY, no write; assert PRESET
//    during WAIT of a write -> all regs 0, PREADY=0, FSM IDLE.
//  6 Back-to-back write @0x00 then read @0x00 without idle -> read returns written value.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave register bank.
package apb_pkg;

    // Transfer-handshake states of the slave FSM.
    typedef enum logic [1:0] {
        APB_IDLE = 2'd0,
        APB_WAIT = 2'd1,
        APB_DONE = 2'd2
    } apb_slv_state_e;

    // Width of the wait-state down-counter (covers 0..15 wait cycles).
    localparam int APB_WAIT_CNT_W = 4;

    // A byte address is only legal when it points at a whole word.
    function automatic logic addr_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/apb_regbank_core.sv
// Register array with byte-strobe writes, read mux and access-error decode.
// Error and read data are combinational on the current APB address phase;
// the registers update only on the cycle the controlling FSM commits.
module apb_regbank_core
    import apb_pkg::*;
#(
    parameter int                  DATA_W   = 32,
    parameter int                  ADDR_W   = 8,
    parameter int                  NUM_REGS = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         commit_s,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic                         PWRITE,
    input  logic [DATA_W-1:0]            PWDATA,
    input  logic [DATA_W/8-1:0]          PSTRB,
    output logic                         err_s,
    output logic [DATA_W-1:0]            rdata_s,
    output logic [NUM_REGS*DATA_W-1:0]   regs_s
);

    localparam int IDX_W     = ADDR_W - 2;
    localparam int NUM_BYTES = DATA_W / 8;

    logic [IDX_W-1:0]    idx_s;
    logic [NUM_REGS-1:0] sel_s;
    logic                in_range_s;
    logic                ro_s;
    logic                we_s;
    logic [DATA_W-1:0]   regs_r [NUM_REGS];

    assign idx_s = PADDR[ADDR_W-1:2];

    // One-hot register select, read mux and error classification.
    always_comb begin
        sel_s   = '0;
        rdata_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel_s[i] = (32'(idx_s) == 32'(i));
            rdata_s  = rdata_s | (regs_r[i] & {DATA_W{sel_s[i]}});
        end
        in_range_s = |sel_s;
        ro_s       = |(sel_s & RO_MASK);
        err_s      = addr_misaligned(PADDR[1:0]) | ~in_range_s | (PWRITE & ro_s);
    end

    assign we_s = commit_s & PWRITE & ~err_s;

    // Byte-lane register update; read-only registers never load and stay zero.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (we_s && sel_s[i] && PSTRB[b] && !RO_MASK[i]) begin
                        regs_r[i][8*b +: 8] <= PWDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    // Flatten the array for the fabric-facing bus.
    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_s[g*DATA_W +: DATA_W] = regs_r[g];
        end
    endgenerate

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave front end: handshake FSM with programmable wait states and
// registered PREADY/PSLVERR/PRDATA around the register bank core.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int                  DATA_W      = 32,
    parameter int                  ADDR_W      = 8,
    parameter int                  NUM_REGS    = 4,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [DATA_W-1:0]            PWDATA,
    input  logic [DATA_W/8-1:0]          PSTRB,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

    // Counter preload: the first wait cycle is spent on the IDLE->WAIT edge.
    localparam logic [APB_WAIT_CNT_W-1:0] WAIT_CNT_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : APB_WAIT_CNT_W'(WAIT_CYCLES - 1);

    apb_slv_state_e              state_r;
    apb_slv_state_e              next_state_s;
    logic [APB_WAIT_CNT_W-1:0]   cnt_r;
    logic [APB_WAIT_CNT_W-1:0]   cnt_next_s;
    logic                        access_s;
    logic                        commit_s;
    logic                        err_s;
    logic [DATA_W-1:0]           rdata_s;
    logic [DATA_W-1:0]           prdata_r;
    logic                        pready_r;
    logic                        pslverr_r;

    assign access_s = PSEL & PENABLE;

    // Next-state and wait-counter logic; an access phase dropped in WAIT aborts.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            APB_IDLE: begin
                if (access_s) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state_s = APB_DONE;
                    end else begin
                        next_state_s = APB_WAIT;
                        cnt_next_s   = WAIT_CNT_INIT;
                    end
                end else begin
                    next_state_s = APB_IDLE;
                end
            end
            APB_WAIT: begin
                if (!access_s) begin
                    next_state_s = APB_IDLE;
                    cnt_next_s   = 4'd0;
                end else if (cnt_r == 4'd0) begin
                    next_state_s = APB_DONE;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            APB_DONE: begin
                next_state_s = APB_IDLE;
            end
            default: begin
                next_state_s = APB_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
        commit_s = (next_state_s == APB_DONE);
    end

    // State, counter and registered APB response; reset overrides any commit.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r   <= APB_IDLE;
            cnt_r     <= 4'd0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= '0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= cnt_next_s;
            pready_r  <= commit_s;
            pslverr_r <= commit_s & err_s;
            if (commit_s && !PWRITE) begin
                prdata_r <= err_s ? '0 : rdata_s;
            end
        end
    end

    assign PRDATA  = prdata_r;
    assign PREADY  = pready_r;
    assign PSLVERR = pslverr_r;

    apb_regbank_core #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK)
    ) u_core (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .commit_s (commit_s),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .err_s    (err_s),
        .rdata_s  (rdata_s),
        .regs_s   (regs_o)
    );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Scoreboard bench for apb_slave_regbank: one instance without wait states,
// one with three; expected responses are queued by the stimulus and checked
// by per-instance monitors whenever PREADY is seen.
module tb_apb_slave_regbank;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic         pclk = 1'b0;
    logic         preset;
    logic [7:0]   paddr;
    logic         psel0, psel3;
    logic         penable;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;

    logic [31:0]  prdata0, prdata3;
    logic         pready0, pready3;
    logic         pslverr0, pslverr3;
    logic [127:0] regs0, regs3;

    exp_t q0[$];
    exp_t q3[$];
    exp_t e0, e3;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_slave_regbank #(
        .DATA_W(32), .ADDR_W(8), .NUM_REGS(4), .WAIT_CYCLES(0), .RO_MASK(4'b1000)
    ) dut0 (
        .PCLK(pclk), .PRESET(preset), .PADDR(paddr), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0),
        .PREADY(pready0), .PSLVERR(pslverr0), .regs_o(regs0)
    );

    apb_slave_regbank #(
        .DATA_W(32), .ADDR_W(8), .NUM_REGS(4), .WAIT_CYCLES(3), .RO_MASK(4'b1000)
    ) dut3 (
        .PCLK(pclk), .PRESET(preset), .PADDR(paddr), .PSEL(psel3), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata3),
        .PREADY(pready3), .PSLVERR(pslverr3), .regs_o(regs3)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor for the zero-wait instance.
    always @(negedge pclk) begin
        if (pready0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_pready", 128'(pready0), 128'(0));
            end else begin
                e0 = q0.pop_front();
                chk("dut0_pslverr", 128'(pslverr0), 128'(e0.err));
                if (e0.rd) chk("dut0_prdata", 128'(prdata0), 128'(e0.data));
            end
        end else begin
            chk("dut0_pslverr_idle", 128'(pslverr0), 128'(0));
        end
    end

    // Monitor for the three-wait instance.
    always @(negedge pclk) begin
        if (pready3 === 1'b1) begin
            if (q3.size() == 0) begin
                chk("dut3_unexpected_pready", 128'(pready3), 128'(0));
            end else begin
                e3 = q3.pop_front();
                chk("dut3_pslverr", 128'(pslverr3), 128'(e3.err));
                if (e3.rd) chk("dut3_prdata", 128'(prdata3), 128'(e3.data));
            end
        end else begin
            chk("dut3_pslverr_idle", 128'(pslverr3), 128'(0));
        end
    end

    // Full APB transfer; queues the expected response and checks latency.
    task automatic xfer(input int sel, input logic wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
        exp_t e;
        int   lat;
        logic done;
        e.rd = ~wr; e.data = exp_rdata; e.err = exp_err;
        if (sel == 0) q0.push_back(e); else q3.push_back(e);
        @(negedge pclk);
        paddr = addr; pwrite = wr; pwdata = data; pstrb = strb;
        penable = 1'b0; psel0 = (sel == 0); psel3 = (sel != 0);
        @(negedge pclk);
        penable = 1'b1;
        lat = 0; done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge pclk);
            lat++;
            if ((sel == 0) ? pready0 : pready3) done = 1'b1;
        end
        chk("latency", 128'(lat), 128'(exp_lat));
    endtask

    task automatic idle();
        @(negedge pclk);
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    // Directed stimulus.
    initial begin
        logic seen;
        preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 8'h00; pwdata = 32'h0; pstrb = 4'h0;
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        chk("reset_regs0", regs0, 128'h0);
        chk("reset_pready0", 128'(pready0), 128'(0));
        chk("reset_pslverr0", 128'(pslverr0), 128'(0));
        chk("reset_prdata0", 128'(prdata0), 128'(0));

        // Basic write/read without wait states.
        xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1);
        idle();
        chk("reg1_deadbeef", 128'(regs0[63:32]), 128'(32'hDEADBEEF));

        // Byte strobes, including an all-zero strobe write.
        xfer(0, 1'b1, 8'h00, 32'h11223344, 4'hF, 1'b0, 32'h0, 1);
        xfer(0, 1'b1, 8'h00, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 1);
        xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'h11BB33DD, 1);
        xfer(0, 1'b1, 8'h08, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, 1);
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0, 32'h0, 1);

        // Illegal accesses: read-only write, out of range, misaligned; legal RO read.
        xfer(0, 1'b1, 8'h0C, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1);
        xfer(0, 1'b1, 8'h10, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1);
        xfer(0, 1'b0, 8'h02, 32'h0, 4'h0, 1'b1, 32'h0, 1);
        xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, 1'b0, 32'h0, 1);
        idle();
        chk("regs0_after_errors", regs0, 128'h00000000_00000000_DEADBEEF_11BB33DD);

        // Back-to-back write then read of the same register.
        xfer(0, 1'b1, 8'h00, 32'h5A5A1234, 4'hF, 1'b0, 32'h0, 1);
        xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'h5A5A1234, 1);
        idle();
        chk("regs0_b2b", regs0, 128'h00000000_00000000_DEADBEEF_5A5A1234);

        // Three wait states.
        xfer(3, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0, 32'h0, 4);
        idle();
        chk("pready_one_cycle", 128'(pready3), 128'(0));
        xfer(3, 1'b1, 8'h08, 32'h0000CAFE, 4'hF, 1'b0, 32'h0, 4);
        xfer(3, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0, 32'h0000CAFE, 4);
        idle();

        // Abort: PSEL dropped while waiting.
        @(negedge pclk);
        paddr = 8'h04; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
        psel3 = 1'b1; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel3 = 1'b0; penable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            if (pready3) seen = 1'b1;
        end
        chk("abort_no_pready", 128'(seen), 128'(0));
        chk("abort_no_write", regs3, 128'h00000000_0000CAFE_00000000_00000000);

        xfer(3, 1'b1, 8'h04, 32'h0000BEEF, 4'hF, 1'b0, 32'h0, 4);
        idle();
        chk("regs3_before_reset", regs3, 128'h00000000_0000CAFE_0000BEEF_00000000);

        // Reset asserted during the wait of a write.
        @(negedge pclk);
        paddr = 8'h04; pwrite = 1'b1; pwdata = 32'h00000055; pstrb = 4'hF;
        psel3 = 1'b1; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0; psel3 = 1'b0; penable = 1'b0;
        chk("reset_mid_regs3", regs3, 128'h0);
        chk("reset_mid_pready3", 128'(pready3), 128'(0));
        chk("reset_mid_regs0", regs0, 128'h0);
        xfer(3, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0, 32'h0, 4);
        idle();
        repeat (2) @(negedge pclk);

        chk("q0_drained", 128'(q0.size()), 128'(0));
        chk("q3_drained", 128'(q3.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
